// File: rtl/mux_arb_4_if.sv
// Request/grant bundle between the requesters and the 4:1 mux arbiter.
// Valid/ready: no handshake. req is a level each cycle, and gnt/sel/busy are registered.
interface mux_arb_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       sel1;
  logic       sel0;
  logic       busy;
  logic       state_dbg;

  modport master (
    output req,
    input  gnt, sel1, sel0, busy, state_dbg
  );

  modport slave (
    input  req,
    output gnt, sel1, sel0, busy, state_dbg
  );
endinterface

// File: rtl/mux_arb_4.sv
// Round-robin arbiter for a shared 4:1 mux path, with a bounded hold time per owner.
// Outputs are registered. The last-owner pointer seeds the search for the next owner.
module mux_arb_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst,
    mux_arb_4_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;

    logic [2:0] pick_all;
    logic [2:0] pick_other;
    logic       take;
    logic [1:0] take_idx;

    // {found, index} of the first set bit of r, searching from p+1 and wrapping back to p.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        take       = 1'b0;
        take_idx   = 2'd0;
        pick_all   = rr_pick(bus.req, last_q);
        pick_other = rr_pick(bus.req & ~gnt_q, last_q);

        case (state_q)
            IDLE: begin
                if (pick_all[2]) begin
                    take     = 1'b1;
                    take_idx = pick_all[1:0];
                end
            end
            GRANT: begin
                // While granted, last_q is the current owner.
                if (bus.req[last_q]) begin
                    if (cnt_q == HOLD_LAST) begin
                        if (pick_other[2]) begin
                            take     = 1'b1;
                            take_idx = pick_other[1:0];
                        end else begin
                            cnt_d = 8'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (pick_all[2]) begin
                    take     = 1'b1;
                    take_idx = pick_all[1:0];
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase

        if (take) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << take_idx;
            sel_d   = take_idx;
            last_d  = take_idx;
            busy_d  = 1'b1;
            cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            last_q  <= 2'd3;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel1      = sel_q[1];
    assign bus.sel0      = sel_q[0];
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mux_arb_4.sv
// Bench for mux_arb_4: directed scenarios plus randomized traffic, checked against an ownership model.
module tb_mux_arb_4;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux_arb_4_if bus_if ();

  mux_arb_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the owner index (-1 when idle) and the number of cycles it has held the grant.
  int m_own;
  int m_last;
  int m_held;
  int m_sel;

  function automatic int first_from(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    return (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_last = 3;
    m_held = 0;
    m_sel  = 0;
  endtask

  task automatic model_update(input logic [3:0] r);
    int nxt;
    logic [3:0] others;
    if (m_own < 0) begin
      nxt = first_from(r, m_last + 1);
      if (nxt >= 0) begin
        m_own = nxt; m_last = nxt; m_sel = nxt; m_held = 1;
      end
    end else if (r[m_own]) begin
      if (m_held == MAX_HOLD) begin
        others = r & ~(4'(1 << m_own));
        nxt = first_from(others, m_own + 1);
        if (nxt >= 0) begin
          m_own = nxt; m_last = nxt; m_sel = nxt;
        end
        m_held = 1;
      end else begin
        m_held++;
      end
    end else begin
      nxt = first_from(r, m_own + 1);
      if (nxt >= 0) begin
        m_own = nxt; m_last = nxt; m_sel = nxt; m_held = 1;
      end else begin
        m_own = -1;
      end
    end
  endtask

  // Drive one request vector, let one edge pass, and sample 1 time unit after that edge.
  task automatic step(input logic [3:0] r);
    bus_if.req = r;
    @(posedge clk);
    model_update(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.req = 4'b0000;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step(4'b1000);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy} !== 7'b0000_00_0) begin
      bad++;
      $display("FAIL reset_async: got gnt=%b sel=%b%b busy=%b want 0000/00/0",
               bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000);
    total++;
    if ({bus_if.gnt, bus_if.busy} !== 5'b0000_0) begin
      bad++;
      $display("FAIL reset_idle: got gnt=%b busy=%b want 0000/0", bus_if.gnt, bus_if.busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0001);
    total++;
    if ({bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy} !== 7'b0001_00_1) begin
      bad++;
      $display("FAIL single_grant: got gnt=%b sel=%b%b busy=%b want 0001/00/1",
               bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      step(4'b1111);
      exp_g = 4'(1 << ((c / MAX_HOLD) % 4));
      total++;
      if (bus_if.gnt !== exp_g) begin
        bad++;
        $display("FAIL rotation c=%0d: got gnt=%b want %b", c, bus_if.gnt, exp_g);
      end
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    step(4'b0101);
    step(4'b0100);
    total++;
    if ({bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy} !== 7'b0100_10_1) begin
      bad++;
      $display("FAIL owner_drop: got gnt=%b sel=%b%b busy=%b want 0100/10/1",
               bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy);
    end
  endtask

  task automatic test_hold_alone();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(4'b0010);
      total++;
      if ({bus_if.gnt, bus_if.busy} !== 5'b0010_1) begin
        bad++;
        $display("FAIL hold_alone c=%0d: got gnt=%b busy=%b want 0010/1", c, bus_if.gnt, bus_if.busy);
      end
    end
  endtask

  task automatic test_idle_return();
    do_reset();
    step(4'b0100);
    step(4'b0000);
    total++;
    if ({bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy} !== 7'b0000_10_0) begin
      bad++;
      $display("FAIL idle_return: got gnt=%b sel=%b%b busy=%b want 0000/10/0",
               bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy);
    end
    step(4'b0011);
    total++;
    if ({bus_if.gnt, bus_if.sel1, bus_if.sel0} !== 6'b0001_00) begin
      bad++;
      $display("FAIL idle_wrap: got gnt=%b sel=%b%b want 0001/00",
               bus_if.gnt, bus_if.sel1, bus_if.sel0);
    end
  endtask

  task automatic test_async_grant();
    do_reset();
    step(4'b0010);
    total++;
    if (bus_if.gnt !== 4'b0010) begin
      bad++;
      $display("FAIL async_pre: got gnt=%b want 0010", bus_if.gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy} !== 7'b0000_00_0) begin
      bad++;
      $display("FAIL async_drop: got gnt=%b sel=%b%b busy=%b want 0000/00/0",
               bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] r;
    int run;
    do_reset();
    r = 4'b0000;
    run = 0;
    for (int c = 0; c < 400; c++) begin
      if (run == 0) begin
        r = 4'($urandom_range(0, 15));
        run = $urandom_range(1, 12);
      end
      run--;
      step(r);
      total++;
      if ({bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy} !==
          {m_gnt(), 2'(m_sel), (m_own >= 0)}) begin
        bad++;
        $display("FAIL random c=%0d req=%b: got gnt=%b sel=%b%b busy=%b want gnt=%b sel=%0d busy=%0d",
                 c, r, bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy,
                 m_gnt(), m_sel, (m_own >= 0));
      end
      total++;
      if ($countones(bus_if.gnt) > 1) begin
        bad++;
        $display("FAIL onehot c=%0d: got gnt=%b want at most one bit", c, bus_if.gnt);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus_if.req = 4'b0000;
    model_reset();
    #1;
    total++;
    if ({bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy} !== 7'b0000_00_0) begin
      bad++;
      $display("FAIL reset_initial: got gnt=%b sel=%b%b busy=%b want 0000/00/0",
               bus_if.gnt, bus_if.sel1, bus_if.sel0, bus_if.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_owner_drop();
    test_hold_alone();
    test_idle_return();
    test_async_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_arb_4.md
MUX_ARB_4 -- requirements
Module: mux_arb_4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles for one owner while others wait (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request vector; req[i] high = requester i wants the shared 4:1 mux path.
REQ-005 gnt  output 4  registered one-hot grant, or 0000.
REQ-006 sel1 output 1  registered MSB of the granted index; drives the 4:1 mux sel1.
REQ-007 sel0 output 1  registered LSB of the granted index; drives the 4:1 mux sel0.
REQ-008 busy output 1  registered; high when any gnt bit is high.

Function
REQ-009 The block SHALL implement two states: IDLE (gnt=0000) and GRANT (exactly one gnt bit high).
REQ-010 The block SHALL keep a 2-bit last-owner pointer; round-robin search order starts at last+1 mod 4 and wraps 3->0.
REQ-011 In IDLE with req!=0000 at a rising edge, the block SHALL enter GRANT and set gnt to the first requester in search order; gnt is visible 1 cycle after req is sampled.
REQ-012 In IDLE with req=0000, the block SHALL stay in IDLE with gnt=0000 and busy=0.
REQ-013 In GRANT, while req[owner]=1, the block SHALL hold the grant and increment an 8-bit hold counter each cycle.
REQ-014 When the hold counter reaches MAX_HOLD-1 and any other req bit is high, the block SHALL move the grant to the next other requester in search order at the next edge and clear the counter.
REQ-015 When the hold counter reaches MAX_HOLD-1 and no other req bit is high, the block SHALL keep the grant and clear the counter; the counter never wraps.
REQ-016 When req[owner]=0 and another req bit is high, the block SHALL grant the next requester in search order at the next edge, with no idle cycle between grants.
REQ-017 When req[owner]=0 and req=0000, the block SHALL return to IDLE at the next edge with gnt=0000 and busy=0.
REQ-018 On every grant change, the block SHALL update the last-owner pointer to the new owner and clear the hold counter.
REQ-019 {sel1,sel0} SHALL equal the binary index of the granted requester, changing in the same cycle as gnt.
REQ-020 In IDLE, {sel1,sel0} SHALL hold the index of the last owner.
REQ-021 gnt SHALL never have more than one bit high in any cycle.
REQ-022 Requests arriving mid-grant SHALL be ignored until a switch point per REQ-014 or REQ-016.

Reset
REQ-023 While rst=1, the block SHALL immediately, without waiting for a clock edge, force:
- gnt=0000, sel1=0, sel0=0, busy=0
- state=IDLE, hold counter=0
- last-owner pointer=3, so the first search starts at requester 0
REQ-024 An assertion of rst during GRANT SHALL drop the grant asynchronously.
REQ-025 After rst deasserts, the first rising edge with req!=0000 SHALL grant per REQ-011.

Verification
REQ-026 rst pulse, then req=0001 -> 1 cycle later gnt=0001, sel=00, busy=1.
REQ-027 MAX_HOLD=8, req=1111 held -> gnt sequence 0001, 0010, 0100, 1000 for 8 cycles each, then wraps to 0001.
REQ-028 Owner 0 granted, req changes 0101->0100 -> next cycle gnt=0100, sel=10, busy stays 1.
REQ-029 req=0010 alone for 20 cycles -> gnt=0010 continuously, no drop at the MAX_HOLD boundary.
REQ-030 Owner 2 granted, req->0000 -> gnt=0000, busy=0, sel stays 10; then req=0011 -> gnt=0001 (search starts at 3, wraps to 0).
REQ-031 Owner 1 granted, rst asserted mid-cycle -> gnt=0000, sel=00, busy=0 before the next clock edge.
